// File: rtl/if_pkg.sv
// Shared widths, fetch-entry layout and branch-target arithmetic for the
// instruction-fetch prefetch stage.
package if_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int OFF_W_DEF   = 6;
    localparam int DEPTH_DEF   = 4;
    localparam int RESET_PC_DEF = 0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Works on 32-bit containers so any PC_W/OFF_W up to 32 can share it;
    // the caller truncates the result to its own PC width.
    function automatic logic [31:0] sext_add(input logic [31:0] base,
                                             input logic [31:0] off,
                                             input int          off_w);
        logic [31:0] ext;
        int          sh;
        sh  = 32 - off_w;
        ext = off << sh;
        ext = $unsigned($signed(ext) >>> sh);
        return base + ext;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch queue; flush wins over push/pop, and the head output
// keeps showing the last presented entry while the queue is empty.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk_ibuf,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] last;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk_ibuf or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Capture whatever is on the head so an empty queue keeps showing it.
            if (!empty) begin
                last <= mem[rd_ptr];
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited fetch from a 1-cycle
// synchronous memory, prefetch queue to decode, and branch redirect/flush.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              OFF_W    = OFF_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk_ibuf,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_pc,
    input  logic [OFF_W-1:0]   branch_offset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic            inflight;
    logic [PC_W-1:0] issued_pc;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            credit_ok;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] redirect_pc;
    entry_t          push_entry;
    entry_t          head_entry;

    // A request is only issued if the queue can absorb it together with the
    // response already on its way back, so a push can never overflow.
    assign credit_ok = ({1'b0, count} + {{CW{1'b0}}, inflight}) < UW'(DEPTH);
    assign imem_req  = ~rst & fetch_en & ~branch_taken & credit_ok & ~full;
    assign imem_addr = pc;

    assign redirect_pc = PC_W'(sext_add(32'(branch_pc), 32'(branch_offset), OFF_W));

    // A redirect in the response cycle kills the returning word.
    assign push             = inflight & ~branch_taken;
    assign pop              = instr_valid & instr_ready;
    assign push_entry.pc    = issued_pc;
    assign push_entry.instr = imem_rdata;

    assign instr_valid = ~empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

    always_ff @(posedge clk_ibuf or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            inflight  <= 1'b0;
            issued_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                issued_pc <= pc;
            end
            if (branch_taken) begin
                pc <= redirect_pc;
            end else if (imem_req) begin
                pc <= pc + 1'b1;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk_ibuf (clk_ibuf),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (branch_taken),
        .din      (push_entry),
        .dout     (head_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: directed scenarios plus random
// traffic against a queue-based reference model, at two parameter sets.
module tb_if_prefetch_unit;

    logic        clk_ibuf = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        branch_taken = 1'b0;
    logic        instr_ready = 1'b0;
    logic [11:0] branch_pc = '0;
    logic [5:0]  branch_offset = '0;

    logic        req_a, valid_a;
    logic [7:0]  addr_a, ipc_a, pc_a;
    logic [15:0] rdata_a, ins_a;
    logic        req_b, valid_b;
    logic [11:0] addr_b, ipc_b, pc_b;
    logic [15:0] rdata_b, ins_b;

    always #5 clk_ibuf = ~clk_ibuf;

    if_prefetch_unit #(.PC_W(8), .INSTR_W(16), .OFF_W(6), .DEPTH(4), .RESET_PC(8'h00)) dut_a (
        .clk_ibuf(clk_ibuf), .rst(rst), .fetch_en(fetch_en), .branch_taken(branch_taken),
        .branch_pc(branch_pc[7:0]), .branch_offset(branch_offset), .imem_req(req_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .instr_valid(valid_a), .instr_ready(instr_ready),
        .instr(ins_a), .instr_pc(ipc_a), .pc(pc_a));

    if_prefetch_unit #(.PC_W(12), .INSTR_W(16), .OFF_W(6), .DEPTH(8), .RESET_PC(12'h000)) dut_b (
        .clk_ibuf(clk_ibuf), .rst(rst), .fetch_en(fetch_en), .branch_taken(branch_taken),
        .branch_pc(branch_pc), .branch_offset(branch_offset), .imem_req(req_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .instr_valid(valid_b), .instr_ready(instr_ready),
        .instr(ins_b), .instr_pc(ipc_b), .pc(pc_b));

    // Synchronous instruction memories: mem[a] = a + 0x100.
    always @(posedge clk_ibuf) begin
        rdata_a <= 16'(16'(addr_a) + 16'h100);
        rdata_b <= 16'(16'(addr_b) + 16'h100);
    end

    bit          sel = 1'b0;
    logic        obs_req, obs_valid;
    logic [11:0] obs_addr, obs_pc, obs_ipc;
    logic [15:0] obs_ins;

    always_comb begin
        obs_req   = sel ? req_b   : req_a;
        obs_valid = sel ? valid_b : valid_a;
        obs_addr  = sel ? addr_b  : {4'h0, addr_a};
        obs_pc    = sel ? pc_b    : {4'h0, pc_a};
        obs_ipc   = sel ? ipc_b   : {4'h0, ipc_a};
        obs_ins   = sel ? ins_b   : ins_a;
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    int pw = 8, dep = 4, mask = 255;
    int m_pc, m_ipc, last_pc, last_ins;
    bit m_infl;
    int q_pc[$];
    int q_ins[$];
    bit cur_br, cur_rdy;
    int cur_bpc, cur_boff;
    bit exp_req, exp_valid;
    int exp_ipc, exp_ins, exp_pc;

    task set_inst(input bit s);
        sel  = s;
        pw   = s ? 12 : 8;
        dep  = s ? 8 : 4;
        mask = (1 << pw) - 1;
    endtask

    task model_reset();
        m_pc = 0; m_ipc = 0; m_infl = 0; last_pc = 0; last_ins = 0;
        q_pc.delete(); q_ins.delete();
    endtask

    task hw_reset();
        fetch_en = 0; branch_taken = 0; instr_ready = 0; branch_pc = 0; branch_offset = 0;
        rst = 1;
        @(negedge clk_ibuf);
        @(negedge clk_ibuf);
        rst = 0;
        model_reset();
    endtask

    task apply(input bit fe, input bit br, input bit rdy, input int bpc, input int boff);
        fetch_en = fe; branch_taken = br; instr_ready = rdy;
        branch_pc = 12'(bpc); branch_offset = 6'(boff);
        cur_br = br; cur_rdy = rdy; cur_bpc = bpc; cur_boff = boff & 63;
        #1;
        exp_req   = fe && !br && (q_pc.size() + int'(m_infl) < dep);
        exp_valid = q_pc.size() > 0;
        exp_ipc   = exp_valid ? q_pc[0] : last_pc;
        exp_ins   = exp_valid ? q_ins[0] : last_ins;
        exp_pc    = m_pc;
    endtask

    task advance();
        int s;
        @(posedge clk_ibuf);
        if (exp_valid) begin
            last_pc = q_pc[0]; last_ins = q_ins[0];
        end
        if (cur_br) begin
            s = (cur_boff >= 32) ? cur_boff - 64 : cur_boff;
            q_pc.delete(); q_ins.delete();
            m_infl = 0;
            m_pc = ((cur_bpc & mask) + s) & mask;
        end else begin
            if (exp_valid && cur_rdy) begin
                void'(q_pc.pop_front()); void'(q_ins.pop_front());
            end
            if (m_infl) begin
                q_pc.push_back(m_ipc); q_ins.push_back((m_ipc + 'h100) & 'hFFFF);
            end
            if (exp_req) begin
                m_infl = 1; m_ipc = m_pc; m_pc = (m_pc + 1) & mask;
            end else begin
                m_infl = 0;
            end
        end
        @(negedge clk_ibuf);
    endtask

    task test_reset();
        fetch_en = 1; instr_ready = 1;
        #1 rst = 1;
        @(negedge clk_ibuf);
        checks += 5;
        if (obs_req !== 1'b0)  begin failures++; $display("[TB] FAIL reset_req got=%0b exp=0", obs_req); end
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", obs_valid); end
        if (obs_pc !== 12'h0)  begin failures++; $display("[TB] FAIL reset_pc got=%0h exp=0", obs_pc); end
        if (obs_ipc !== 12'h0) begin failures++; $display("[TB] FAIL reset_instr_pc got=%0h exp=0", obs_ipc); end
        if (obs_ins !== 16'h0) begin failures++; $display("[TB] FAIL reset_instr got=%0h exp=0", obs_ins); end
        fetch_en = 0;
        @(negedge clk_ibuf);
        rst = 0;
        model_reset();
    endtask

    task test_stream();
        hw_reset();
        for (int i = 0; i < 14; i++) begin
            apply(1, 0, 1, 0, 0);
            checks += 5;
            if (obs_req !== exp_req) begin failures++; $display("[TB] FAIL stream_req cyc=%0d got=%0b exp=%0b", i, obs_req, exp_req); end
            if (obs_valid !== exp_valid) begin failures++; $display("[TB] FAIL stream_valid cyc=%0d got=%0b exp=%0b", i, obs_valid, exp_valid); end
            if (obs_pc !== 12'(exp_pc)) begin failures++; $display("[TB] FAIL stream_pc cyc=%0d got=%0h exp=%0h", i, obs_pc, exp_pc); end
            if (obs_ipc !== 12'(exp_ipc)) begin failures++; $display("[TB] FAIL stream_instr_pc cyc=%0d got=%0h exp=%0h", i, obs_ipc, exp_ipc); end
            if (obs_ins !== 16'(exp_ins)) begin failures++; $display("[TB] FAIL stream_instr cyc=%0d got=%0h exp=%0h", i, obs_ins, exp_ins); end
            if (exp_req) begin
                checks++;
                if (obs_addr !== 12'(exp_pc)) begin failures++; $display("[TB] FAIL stream_addr cyc=%0d got=%0h exp=%0h", i, obs_addr, exp_pc); end
            end
            if (i == 1) begin
                checks++;
                if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early got=%0b exp=0", obs_valid); end
            end
            if (i == 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_ipc !== 12'h0 || obs_ins !== 16'h100) begin
                    failures++; $display("[TB] FAIL latency_first got=%0b/%0h/%0h exp=1/0/100", obs_valid, obs_ipc, obs_ins);
                end
            end
            advance();
        end
    endtask

    task test_backpressure();
        int n, nxt;
        hw_reset();
        n = 0;
        for (int i = 0; i < dep + 4; i++) begin
            apply(1, 0, 0, 0, 0);
            if (obs_req) n++;
            advance();
        end
        checks += 2;
        if (n != dep) begin failures++; $display("[TB] FAIL full_req_count got=%0d exp=%0d", n, dep); end
        if (obs_pc !== 12'(dep)) begin failures++; $display("[TB] FAIL full_pc_hold got=%0h exp=%0h", obs_pc, dep); end
        nxt = 0;
        for (int i = 0; i < 3 * dep; i++) begin
            apply(1, 0, 1, 0, 0);
            if (obs_valid) begin
                checks++;
                if (obs_ipc !== 12'(nxt) || obs_ins !== 16'(nxt + 'h100)) begin
                    failures++; $display("[TB] FAIL drain_order got=%0h/%0h exp=%0h/%0h", obs_ipc, obs_ins, nxt, nxt + 'h100);
                end
                nxt++;
            end
            advance();
        end
        checks++;
        if (nxt < dep + 2) begin failures++; $display("[TB] FAIL drain_resume got=%0d exp>=%0d", nxt, dep + 2); end
    endtask

    task test_branch_flush();
        int guard;
        int first;
        hw_reset();
        guard = 0;
        while (!(q_pc.size() > 0 && q_pc[0] == 5) && guard < 40) begin
            apply(1, 0, 1, 0, 0);
            advance();
            guard++;
        end
        checks++;
        if (guard >= 40) begin failures++; $display("[TB] FAIL branch_setup timeout got=%0d exp<40", guard); end
        apply(1, 0, 0, 0, 0); advance();
        apply(1, 0, 0, 0, 0); advance();
        apply(1, 1, 1, 6, 'h3D);
        checks += 2;
        if (obs_valid !== 1'b1 || obs_ipc !== 12'h5) begin failures++; $display("[TB] FAIL branch_pre_head got=%0b/%0h exp=1/5", obs_valid, obs_ipc); end
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL branch_cycle_req got=%0b exp=0", obs_req); end
        advance();
        apply(1, 0, 1, 0, 0);
        checks += 2;
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL branch_flush_valid got=%0b exp=0", obs_valid); end
        if (obs_pc !== 12'h3) begin failures++; $display("[TB] FAIL branch_target got=%0h exp=3", obs_pc); end
        first = -1;
        for (int i = 0; i < 8 && first < 0; i++) begin
            advance();
            apply(1, 0, 1, 0, 0);
            if (obs_valid) first = int'(obs_ipc);
        end
        checks++;
        if (first != 3) begin failures++; $display("[TB] FAIL branch_first_delivered got=%0d exp=3", first); end
        advance();
    endtask

    task test_wrap();
        hw_reset();
        apply(0, 1, 1, 'hFF, 0); advance();
        apply(1, 0, 1, 0, 0);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 12'hFF) begin failures++; $display("[TB] FAIL wrap_ff got=%0b/%0h exp=1/ff", obs_req, obs_addr); end
        advance();
        apply(1, 0, 1, 0, 0);
        checks++;
        if (obs_addr !== 12'h00) begin failures++; $display("[TB] FAIL wrap_00 got=%0h exp=0", obs_addr); end
        advance();
        apply(1, 1, 1, 'hFE, 5); advance();
        apply(0, 0, 1, 0, 0);
        checks++;
        if (obs_pc !== 12'h03) begin failures++; $display("[TB] FAIL wrap_branch got=%0h exp=3", obs_pc); end
        advance();
    endtask

    task test_branch_collision();
        hw_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, 1, 0, 0); advance();
        end
        apply(1, 1, 1, 20, 0);
        checks += 2;
        if (obs_valid !== 1'b1) begin failures++; $display("[TB] FAIL collide_pre_valid got=%0b exp=1", obs_valid); end
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL collide_idle_req got=%0b exp=0", obs_req); end
        advance();
        apply(1, 0, 1, 0, 0);
        checks += 2;
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL collide_flush got=%0b exp=0", obs_valid); end
        if (obs_req !== 1'b1 || obs_addr !== 12'd20) begin failures++; $display("[TB] FAIL collide_resume got=%0b/%0h exp=1/14", obs_req, obs_addr); end
        advance();
        apply(1, 0, 1, 0, 0);
        checks++;
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL collide_killed got=%0b exp=0", obs_valid); end
        advance();
        apply(1, 0, 1, 0, 0);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 12'd20) begin failures++; $display("[TB] FAIL collide_target got=%0b/%0h exp=1/14", obs_valid, obs_ipc); end
        advance();
    endtask

    task test_async_reset();
        hw_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, 1, 0, 0); advance();
        end
        #2 rst = 1;
        #1;
        checks += 4;
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_valid got=%0b exp=0", obs_valid); end
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL arst_req got=%0b exp=0", obs_req); end
        if (obs_pc !== 12'h0) begin failures++; $display("[TB] FAIL arst_pc got=%0h exp=0", obs_pc); end
        if (obs_ipc !== 12'h0 || obs_ins !== 16'h0) begin failures++; $display("[TB] FAIL arst_head got=%0h/%0h exp=0/0", obs_ipc, obs_ins); end
        fetch_en = 0;
        #1 rst = 0;
        model_reset();
        @(negedge clk_ibuf);
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 1, 0, 0);
            if (i == 0) begin
                checks++;
                if (obs_req !== 1'b1 || obs_addr !== 12'h0) begin failures++; $display("[TB] FAIL arst_restart got=%0b/%0h exp=1/0", obs_req, obs_addr); end
            end
            if (i == 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_ipc !== 12'h0) begin failures++; $display("[TB] FAIL arst_first got=%0b/%0h exp=1/0", obs_valid, obs_ipc); end
            end
            advance();
        end
    endtask

    task test_random(input int n);
        bit fe, br, rdy;
        hw_reset();
        for (int i = 0; i < n; i++) begin
            fe  = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            apply(fe, br, rdy, int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)));
            checks += 5;
            if (obs_req !== exp_req) begin failures++; $display("[TB] FAIL rand_req sel=%0d cyc=%0d got=%0b exp=%0b", sel, i, obs_req, exp_req); end
            if (obs_valid !== exp_valid) begin failures++; $display("[TB] FAIL rand_valid sel=%0d cyc=%0d got=%0b exp=%0b", sel, i, obs_valid, exp_valid); end
            if (obs_pc !== 12'(exp_pc)) begin failures++; $display("[TB] FAIL rand_pc sel=%0d cyc=%0d got=%0h exp=%0h", sel, i, obs_pc, exp_pc); end
            if (obs_ipc !== 12'(exp_ipc)) begin failures++; $display("[TB] FAIL rand_instr_pc sel=%0d cyc=%0d got=%0h exp=%0h", sel, i, obs_ipc, exp_ipc); end
            if (obs_ins !== 16'(exp_ins)) begin failures++; $display("[TB] FAIL rand_instr sel=%0d cyc=%0d got=%0h exp=%0h", sel, i, obs_ins, exp_ins); end
            if (exp_req) begin
                checks++;
                if (obs_addr !== 12'(exp_pc)) begin failures++; $display("[TB] FAIL rand_addr sel=%0d cyc=%0d got=%0h exp=%0h", sel, i, obs_addr, exp_pc); end
            end
            advance();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        set_inst(0);
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_flush();
        test_wrap();
        test_branch_collision();
        test_async_reset();
        test_random(400);
        set_inst(1);
        test_stream();
        test_backpressure();
        test_branch_collision();
        test_async_reset();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
